// File: rtl/buffet_filler.sv
// buffet_filler: producer-side credit endpoint of the buffet fill protocol.
// Optional feature macro BUFFET_FILLER_OVERLAP_EN keeps accepting during refills.
module buffet_filler #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int REFILL_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  nreset_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [DATA_WIDTH-1:0] push_data_o,
    output logic                  push_valid_o,
    output logic                  credit_req_o,
    input  logic [ADDR_WIDTH-1:0] credit_in_i,
    input  logic                  credit_valid_i,
    output logic [ADDR_WIDTH-1:0] credit_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] credit_cnt;
    logic [1:0]            inflight;
    logic                  accept;
    logic                  cnt_nz;
    logic                  resp;
    logic [ADDR_WIDTH-1:0] cnt_after;
    logic [ADDR_WIDTH-1:0] infl_tot;
    logic [ADDR_WIDTH-1:0] load_val;

    assign cnt_nz = (credit_cnt != '0);

`ifdef BUFFET_FILLER_OVERLAP_EN
    assign in_ready_o = cnt_nz && (state != IDLE);
`else
    assign in_ready_o = cnt_nz && (state == RUN);
`endif

    assign accept    = in_valid_i & in_ready_o;
    assign resp      = (state == WAIT) && credit_valid_i;
    assign cnt_after = credit_cnt - ADDR_WIDTH'(accept);

    // The reply does not see words accepted from T-1 onward, including this cycle.
    assign infl_tot = ADDR_WIDTH'(inflight) + ADDR_WIDTH'(accept);
    assign load_val = (credit_in_i > infl_tot) ? (credit_in_i - infl_tot) : '0;

    assign credit_req_o = (state == REQ);
    assign credit_cnt_o = credit_cnt;

    // State register.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: request, wait for the absolute credit, run until near empty.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (credit_valid_i) begin
                    state_nxt = (load_val == '0) ? REQ : RUN;
                end
            end
            RUN: begin
                if (cnt_after <= ADDR_WIDTH'(REFILL_THRESH)) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Credit counter: absolute reload on response, one down per accept.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            credit_cnt <= '0;
        end else if (resp) begin
            credit_cnt <= load_val;
        end else if (accept) begin
            credit_cnt <= cnt_after;
        end
    end

    // Inflight: restarts with the T-1 accept, saturates at 3 during REQ/WAIT.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            inflight <= '0;
        end else if (state_nxt == REQ) begin
            inflight <= {1'b0, accept};
        end else if (accept && (inflight != 2'd3)) begin
            inflight <= inflight + 2'd1;
        end
    end

    // Push strobe follows an accept by one cycle.
    always_ff @(posedge clk or negedge nreset_i) begin
        if (!nreset_i) begin
            push_valid_o <= 1'b0;
        end else begin
            push_valid_o <= accept;
        end
    end

    // Push data captured on accept; meaningless while the strobe is low.
    always_ff @(posedge clk) begin
        if (accept) begin
            push_data_o <= in_data_i;
        end
    end

endmodule

// File: tb/tb_buffet_filler.sv
// tb_buffet_filler: directed and randomized checks of buffet_filler
// against a credit-budget / scoreboard reference model.
module tb_buffet_filler;

    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TH  = 2;
    localparam int CAP = 40;

`ifdef BUFFET_FILLER_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_WAIT = 2;
    localparam int P_RUN  = 3;

    logic          clk = 1'b0;
    logic          nreset_i = 1'b0;
    logic [DW-1:0] in_data_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] push_data_o;
    logic          push_valid_o;
    logic          credit_req_o;
    logic [AW-1:0] credit_in_i = '0;
    logic          credit_valid_i = 1'b0;
    logic [AW-1:0] credit_cnt_o;

    buffet_filler #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .REFILL_THRESH(TH)
    ) dut (
        .clk           (clk),
        .nreset_i      (nreset_i),
        .in_data_i     (in_data_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .push_data_o   (push_data_o),
        .push_valid_o  (push_valid_o),
        .credit_req_o  (credit_req_o),
        .credit_in_i   (credit_in_i),
        .credit_valid_i(credit_valid_i),
        .credit_cnt_o  (credit_cnt_o)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc;
    int          phase;
    int          m_cnt;
    int          t_req;
    int          acc_hist[$];
    logic [31:0] sb[$];
    int          resp_q[$];
    bit          exp_pv;
    int          vmode;
    bit          tog;
    logic [31:0] src_word = 32'd0;
    int          delay_left;
    bit          rnd;
    int          occ;
    int          occ_at_t;
    int          pushes;
    int          reqs;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)",
                   tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        phase  = P_IDLE;
        m_cnt  = 0;
        t_req  = 0;
        exp_pv = 1'b0;
        cyc    = 0;
        occ    = 0;
        occ_at_t = 0;
        pushes = 0;
        reqs   = 0;
        delay_left = 0;
        sb.delete();
        acc_hist.delete();
        resp_q.delete();
    endtask

    // Hold reset for 3 cycles checking quiet outputs, release at a negedge.
    task automatic do_reset();
        nreset_i       = 1'b0;
        in_valid_i     = 1'b0;
        credit_valid_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_push_valid", 32'(push_valid_o), 32'd0);
            chk("rst_credit_req", 32'(credit_req_o), 32'd0);
            chk("rst_in_ready", 32'(in_ready_o), 32'd0);
            chk("rst_credit_cnt", 32'(credit_cnt_o), 32'd0);
        end
        nreset_i = 1'b1;
        model_clear();
    endtask

    // One clock cycle: drive, check against model, advance model past the edge.
    task automatic cycle();
        bit          v;
        bit          cv;
        bit          acc;
        bit          ready_e;
        logic [AW-1:0] ci;
        int          tot;
        int          free;

        unique case (vmode)
            0: v = 1'b1;
            1: begin v = tog; tog = ~tog; end
            default: v = ($urandom_range(0, 3) != 0);
        endcase

        cv = 1'b0;
        ci = '0;
        if (phase == P_WAIT) begin
            if (delay_left == 0) begin
                cv = 1'b1;
                if (resp_q.size() > 0) begin
                    ci = AW'(resp_q.pop_front());
                end else begin
                    free = CAP - occ_at_t;
                    ci = AW'((free > 0) ? free : 0);
                end
            end else begin
                delay_left--;
            end
        end else if (rnd && ($urandom_range(0, 7) == 0)) begin
            cv = 1'b1;
            ci = AW'($urandom);
        end

        in_valid_i     = v;
        in_data_i      = src_word;
        credit_valid_i = cv;
        credit_in_i    = ci;
        #1;

        ready_e = (m_cnt > 0) &&
                  (OVL ? (phase != P_IDLE) : (phase == P_RUN));
        chk("in_ready", 32'(in_ready_o), 32'(ready_e));
        chk("credit_req", 32'(credit_req_o), 32'(phase == P_REQ));
        chk("credit_cnt", 32'(credit_cnt_o), 32'(m_cnt));
        chk("push_valid", 32'(push_valid_o), 32'(exp_pv));
        if (exp_pv && sb.size() > 0) begin
            chk("push_data", push_data_o, sb.pop_front());
        end
        if (credit_req_o === 1'b1) reqs++;

        if (phase == P_REQ) occ_at_t = occ;
        if (push_valid_o === 1'b1) begin
            pushes++;
            occ++;
            if (rnd) chk("buffet_overflow", 32'(occ <= CAP), 32'd1);
        end
        if (rnd && occ > 0 && $urandom_range(0, 2) == 0) occ--;

        acc    = v && ready_e;
        exp_pv = acc;
        if (acc) begin
            sb.push_back(src_word);
            acc_hist.push_back(cyc);
            if (acc_hist.size() > 8) void'(acc_hist.pop_front());
            src_word++;
            m_cnt--;
        end

        unique case (phase)
            P_IDLE: begin
                phase = P_REQ;
                t_req = cyc + 1;
            end
            P_REQ: begin
                phase = P_WAIT;
                delay_left = rnd ? $urandom_range(0, 3) : 0;
            end
            P_WAIT: begin
                if (cv) begin
                    tot = 0;
                    foreach (acc_hist[i]) if (acc_hist[i] >= t_req - 1) tot++;
                    m_cnt = (int'(ci) > tot) ? int'(ci) - tot : 0;
                    if (m_cnt == 0) begin
                        phase = P_REQ;
                        t_req = cyc + 1;
                    end else begin
                        phase = P_RUN;
                    end
                end
            end
            default: begin
                if (m_cnt <= TH) begin
                    phase = P_REQ;
                    t_req = cyc + 1;
                end
            end
        endcase

        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int r0;
        rnd   = 1'b0;
        vmode = 0;
        tog   = 1'b1;
        model_clear();

        // Reset, then credit 5 with in_valid held high.
        do_reset();
        resp_q.push_back(5);
        resp_q.push_back(0);
        resp_q.push_back(0);
        resp_q.push_back(6);
        resp_q.push_back(10);
        repeat (7) cycle();
        chk("credit5_pushes", 32'(pushes), 32'd3);
        chk("credit5_reqs", 32'(reqs), 32'd2);

        // Two zero responses: re-poll every 2 cycles.
        r0 = reqs;
        repeat (4) cycle();
        chk("zero_repoll", 32'(reqs - r0), 32'd2);

        // Credit 6 then refill at count 3, response 10.
        repeat (7) cycle();
        #1;
        chk("refill_load", 32'(credit_cnt_o), OVL ? 32'd7 : 32'd9);
        repeat (4) cycle();

        // Upstream gaps with credit 8.
        do_reset();
        resp_q.push_back(8);
        vmode = 1;
        tog   = 1'b1;
        repeat (14) cycle();
        chk("gap_pushes", 32'(pushes), 32'd5);

        // Mid-stream reset while running with 6 credits.
        do_reset();
        resp_q.push_back(8);
        vmode = 0;
        repeat (5) cycle();
        #1;
        chk("pre_rst_cnt", 32'(credit_cnt_o), 32'd6);
        chk("pre_rst_pv", 32'(push_valid_o), 32'd1);
        nreset_i = 1'b0;
        #1;
        chk("async_push_valid", 32'(push_valid_o), 32'd0);
        chk("async_credit_cnt", 32'(credit_cnt_o), 32'd0);
        chk("async_in_ready", 32'(in_ready_o), 32'd0);
        do_reset();
        resp_q.push_back(4);
        repeat (3) cycle();
        chk("post_rst_reqs", 32'(reqs), 32'd1);

        // Randomized traffic against a buffet occupancy model.
        do_reset();
        rnd   = 1'b1;
        vmode = 2;
        repeat (600) cycle();
        chk("random_progress", 32'(pushes > 50), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/buffet_filler.md
# buffet_filler

Producer-side credit endpoint of the buffet fill protocol. It takes an upstream valid/ready data stream and requests credit (free space) from `buffet_control`. It then drives `push_data`/`push_valid` into the buffet and never pushes more words than the last credit response allows. It sits between a DRAM/NoC stream source and the buffet controller's push and credit ports.

## Interface
- `DATA_WIDTH`, 32, width of pushed data words.
- `ADDR_WIDTH`, 8, buffet index width; sets credit value width and credit counter width.
- `REFILL_THRESH`, 2, a new credit request is issued when remaining credit after the current cycle is ≤ this value.
- `clk` in 1 clock, all state on rising edge.
- `nreset_i` in 1 reset: asynchronous, active-low.
- `in_data_i` in DATA_WIDTH upstream data.
- `in_valid_i` in 1 upstream data valid.
- `in_ready_o` out 1 upstream ready; combinational from state and credit counter.
- `push_data_o` out DATA_WIDTH registered data to the buffet push port.
- `push_valid_o` out 1 registered push strobe; one word per high cycle; no backpressure.
- `credit_req_o` out 1 credit request to the buffet; decode of the registered state.
- `credit_in_i` in ADDR_WIDTH absolute free space reported by the buffet.
- `credit_valid_i` in 1 `credit_in_i` is valid this cycle.
- `credit_cnt_o` out ADDR_WIDTH current credit counter (debug/status).

## Operation
- Accept: `in_valid_i & in_ready_o`. Each accept consumes one credit in the same cycle. The accepted word appears on `push_data_o`/`push_valid_o` the next cycle.
- FSM states: IDLE, REQ, WAIT, RUN. Reset state is IDLE.
  - IDLE → REQ unconditionally. IDLE is entered only from reset.
  - REQ: `credit_req_o`=1 for exactly one cycle. REQ → WAIT.
  - WAIT: hold until `credit_valid_i`.
    - On response: `credit_cnt` ← `credit_in_i` − inflight (clamped at 0).
    - If the loaded value is 0 → REQ (re-poll); otherwise → RUN.
  - RUN: if `credit_cnt` − accept_this_cycle ≤ REFILL_THRESH → REQ; otherwise stay in RUN.
- Inflight definition: let T be the cycle in which `credit_req_o`=1. The buffet's reply reflects pushes issued strictly before T, i.e. accepts at cycles ≤ T−2. Inflight = number of accepts in cycles T−1, T, and the response cycle. It is tracked in a 2-bit counter cleared on entering REQ, and the response-cycle accept is added combinationally.
- The credit value is absolute, so it replaces the counter rather than adding to it. Stale remaining credit is discarded on load.
- `credit_valid_i` outside WAIT is ignored.
- `credit_cnt` never underflows; `in_ready_o`=0 whenever `credit_cnt`=0.

## Timing
- Reset values:
  - `push_valid_o`=0, `credit_req_o`=0, `in_ready_o`=0, `credit_cnt_o`=0.
  - `push_data_o` is not reset (don't-care while `push_valid_o`=0).
- First post-reset edge: IDLE → REQ, so `credit_req_o` is high in cycle 1.
- The buffet responds at T+1, so the minimum round trip is 2 cycles from REQ entry to RUN.
- Accept-to-push latency: 1 cycle. Peak throughput: 1 word/cycle in RUN.
- Simultaneous accept and credit load in the WAIT response cycle: that accept counts in inflight, and the counter loads `credit_in_i` − inflight including it.
- Reset asserted mid-operation: FSM → IDLE, `push_valid_o` drops asynchronously, and credit/inflight counters clear. Any word registered but not yet pushed is lost.

## Configuration
- `BUFFET_FILLER_OVERLAP_EN` defined:
  - `in_ready_o` = (`credit_cnt` > 0) in RUN, REQ and WAIT, so pushes continue through the credit round trip.
  - Inflight may reach 3 (saturating 2-bit counter).
- Not defined:
  - `in_ready_o` = (state==RUN & `credit_cnt` > 0).
  - Inflight ≤ 1, since only the T−1 accept can occur.
  - A 2-cycle push bubble occurs per refill.

## Test plan
- Reset: hold `nreset_i`=0 for 3 cycles, then release → all outputs 0 during reset; `credit_req_o`=1 in exactly cycle 1 after release, then 0.
- Credit 5, no overlap: respond `credit_in_i`=5 at T+1 while `in_valid_i` is held high with words 0..9.
  - Exactly words 0,1,2 are pushed (credit 5→2 hits REFILL_THRESH), then `credit_req_o` pulses.
  - `push_valid_o` stays low in REQ and WAIT.
- Zero credit: respond `credit_in_i`=0 → `in_ready_o` stays 0 and `credit_req_o` re-pulses every 2 cycles until a nonzero response arrives.
- Overlap (macro on), `credit_cnt`=3 at refill, `in_valid_i` continuous, response `credit_in_i`=10:
  - Accepts occur at T−1, T and T+1 (inflight=3), and `credit_cnt_o` loads 7.
  - Total pushes never exceed the buffet's reported space.
- Upstream gaps: `in_valid_i` toggles 1,0,1,0 with credit 8 → one push per valid cycle at 1-cycle latency, with data matching inputs in order.
- Mid-stream reset: assert `nreset_i` while in RUN with `credit_cnt`=6 → `push_valid_o`=0 immediately and `credit_cnt_o`=0; after release, a fresh REQ occurs in cycle 1.
